// File: rtl/tile_frame_sequencer.sv
// Frame/tile sequencer: triggers binning, issues screen tiles in raster order to the
// rasterizer and framebuffer streamer through a ring of tile buffers, swaps on vblank.
module tile_frame_sequencer #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int TILE_DIM      = 16,
  parameter int NUM_TILE_BUFS = 2,
  parameter int BUF_W         = $clog2(NUM_TILE_BUFS)
) (
  input  logic             BOARD_CLK,
  input  logic             Reset,
  input  logic             frameEnable,
  input  logic             frameStep,
  input  logic             vblank,
  output logic             startBinning,
  input  logic             doneBinning,
  output logic             rasterStart,
  output logic [BUF_W-1:0] rasterTileID,
  output logic [9:0]       rasterxOffset,
  output logic [9:0]       rasteryOffset,
  input  logic             doneRasterizing,
  output logic             streamStart,
  output logic [BUF_W-1:0] streamTileID,
  output logic [9:0]       streamxOffset,
  output logic [9:0]       streamyOffset,
  input  logic             doneStreaming,
  output logic             doubleBuffer,
  output logic [15:0]      frameCount,
  output logic             busy,
  output logic             protocolError
);
  localparam int TILES_X   = (SCREEN_W + TILE_DIM - 1) / TILE_DIM;
  localparam int TILES_Y   = (SCREEN_H + TILE_DIM - 1) / TILE_DIM;
  localparam int NUM_TILES = TILES_X * TILES_Y;
  localparam int CNT_W     = $clog2(NUM_TILES + 1);

  localparam logic [CNT_W-1:0] TILES_C  = CNT_W'(NUM_TILES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [BUF_W-1:0] ID_ONE   = BUF_W'(1'b1);
  localparam logic [BUF_W-1:0] ID_ZERO  = BUF_W'(1'b0);
  localparam logic [BUF_W:0]   BUFS_C   = (BUF_W + 1)'(NUM_TILE_BUFS);
  localparam logic [BUF_W:0]   B_ONE    = (BUF_W + 1)'(1'b1);
  localparam logic [BUF_W:0]   B_ZERO   = (BUF_W + 1)'(1'b0);
  localparam logic [9:0]       STEP_C   = 10'(TILE_DIM);
  localparam logic [9:0]       LAST_X_C = 10'((TILES_X - 1) * TILE_DIM);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BIN_START = 3'd1,
    ST_BIN_WAIT  = 3'd2,
    ST_TILES     = 3'd3,
    ST_SWAP_WAIT = 3'd4,
    ST_SWAP      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       r_x_q, r_x_d, r_y_q, r_y_d, s_x_q, s_x_d, s_y_q, s_y_d;
  logic [BUF_W-1:0] r_id_q, r_id_d, s_id_q, s_id_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d, s_cnt_q, s_cnt_d;
  logic [BUF_W:0]   free_q, free_d, ready_q, ready_d;
  logic             r_busy_q, r_busy_d, s_busy_q, s_busy_d, vblank_q;
  logic             start_bin_q, start_bin_d, raster_start_q, raster_start_d;
  logic             stream_start_q, stream_start_d, dbuf_q, dbuf_d;
  logic             busy_q, busy_d, perr_q, perr_d;
  logic [BUF_W-1:0] raster_id_q, raster_id_d, stream_id_q, stream_id_d;
  logic [9:0]       raster_x_q, raster_x_d, raster_y_q, raster_y_d;
  logic [9:0]       stream_x_q, stream_x_d, stream_y_q, stream_y_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             r_done_v, s_done_v, r_issue, s_issue;

  // Raster-order step, packed as {y, x}; the column wraps after the last (possibly partial) tile.
  function automatic logic [19:0] next_xy(input logic [9:0] x, input logic [9:0] y);
    if (x == LAST_X_C) begin
      next_xy = {y + STEP_C, 10'd0};
    end else begin
      next_xy = {y, x + STEP_C};
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    r_x_d       = r_x_q;
    r_y_d       = r_y_q;
    s_x_d       = s_x_q;
    s_y_d       = s_y_q;
    r_id_d      = r_id_q;
    s_id_d      = s_id_q;
    r_cnt_d     = r_cnt_q;
    s_cnt_d     = s_cnt_q;
    raster_id_d = raster_id_q;
    raster_x_d  = raster_x_q;
    raster_y_d  = raster_y_q;
    stream_id_d = stream_id_q;
    stream_x_d  = stream_x_q;
    stream_y_d  = stream_y_q;
    dbuf_d      = dbuf_q;
    frame_cnt_d = frame_cnt_q;

    // A done pulse only counts when its engine has a tile outstanding.
    r_done_v = doneRasterizing & r_busy_q;
    s_done_v = doneStreaming & s_busy_q;
    r_issue  = (state_q == ST_TILES) & (~r_busy_q | r_done_v) & (free_q != B_ZERO)
               & (r_cnt_q != TILES_C);
    s_issue  = (state_q == ST_TILES) & (~s_busy_q | s_done_v) & ((ready_q != B_ZERO) | r_done_v)
               & (s_cnt_q != TILES_C);
    raster_start_d = r_issue;
    stream_start_d = s_issue;
    r_busy_d = r_issue | (r_busy_q & ~r_done_v);
    s_busy_d = s_issue | (s_busy_q & ~s_done_v);
    perr_d   = perr_q | (doneRasterizing & ~r_busy_q) | (doneStreaming & ~s_busy_q)
               | (doneBinning & (state_q != ST_BIN_WAIT));

    if (r_issue) begin
      raster_x_d     = r_x_q;
      raster_y_d     = r_y_q;
      raster_id_d    = r_id_q;
      {r_y_d, r_x_d} = next_xy(r_x_q, r_y_q);
      r_id_d         = r_id_q + ID_ONE;
      r_cnt_d        = r_cnt_q + CNT_ONE;
    end else begin
      r_cnt_d = r_cnt_q;
    end

    if (s_issue) begin
      stream_x_d     = s_x_q;
      stream_y_d     = s_y_q;
      stream_id_d    = s_id_q;
      {s_y_d, s_x_d} = next_xy(s_x_q, s_y_q);
      s_id_d         = s_id_q + ID_ONE;
      s_cnt_d        = s_cnt_q + CNT_ONE;
    end else begin
      s_cnt_d = s_cnt_q;
    end

    case ({r_issue, s_done_v})
      2'b10:   free_d = free_q - B_ONE;
      2'b01:   free_d = free_q + B_ONE;
      default: free_d = free_q;
    endcase

    case ({r_done_v, s_issue})
      2'b10:   ready_d = ready_q + B_ONE;
      2'b01:   ready_d = ready_q - B_ONE;
      default: ready_d = ready_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (frameEnable | frameStep) begin
          state_d = ST_BIN_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BIN_START: begin
        state_d  = ST_BIN_WAIT;
        r_x_d    = 10'd0;
        r_y_d    = 10'd0;
        s_x_d    = 10'd0;
        s_y_d    = 10'd0;
        r_id_d   = ID_ZERO;
        s_id_d   = ID_ZERO;
        r_cnt_d  = CNT_ZERO;
        s_cnt_d  = CNT_ZERO;
        free_d   = BUFS_C;
        ready_d  = B_ZERO;
        r_busy_d = 1'b0;
        s_busy_d = 1'b0;
      end
      ST_BIN_WAIT: begin
        if (doneBinning) begin
          state_d = ST_TILES;
        end else begin
          state_d = ST_BIN_WAIT;
        end
      end
      ST_TILES: begin
        // Everything has been issued once s_cnt saturates, so the next stream done is the last.
        if (s_done_v & (s_cnt_q == TILES_C)) begin
          state_d = ST_SWAP_WAIT;
        end else begin
          state_d = ST_TILES;
        end
      end
      ST_SWAP_WAIT: begin
        if (vblank & ~vblank_q) begin
          state_d     = ST_SWAP;
          dbuf_d      = ~dbuf_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          state_d = ST_SWAP_WAIT;
        end
      end
      ST_SWAP: begin
        if (frameEnable) begin
          state_d = ST_BIN_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_bin_d = (state_d == ST_BIN_START);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge BOARD_CLK) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      r_x_q          <= 10'd0;
      r_y_q          <= 10'd0;
      s_x_q          <= 10'd0;
      s_y_q          <= 10'd0;
      r_id_q         <= ID_ZERO;
      s_id_q         <= ID_ZERO;
      r_cnt_q        <= CNT_ZERO;
      s_cnt_q        <= CNT_ZERO;
      free_q         <= BUFS_C;
      ready_q        <= B_ZERO;
      r_busy_q       <= 1'b0;
      s_busy_q       <= 1'b0;
      vblank_q       <= 1'b0;
      start_bin_q    <= 1'b0;
      raster_start_q <= 1'b0;
      stream_start_q <= 1'b0;
      raster_id_q    <= ID_ZERO;
      raster_x_q     <= 10'd0;
      raster_y_q     <= 10'd0;
      stream_id_q    <= ID_ZERO;
      stream_x_q     <= 10'd0;
      stream_y_q     <= 10'd0;
      dbuf_q         <= 1'b0;
      frame_cnt_q    <= 16'd0;
      busy_q         <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      r_x_q          <= r_x_d;
      r_y_q          <= r_y_d;
      s_x_q          <= s_x_d;
      s_y_q          <= s_y_d;
      r_id_q         <= r_id_d;
      s_id_q         <= s_id_d;
      r_cnt_q        <= r_cnt_d;
      s_cnt_q        <= s_cnt_d;
      free_q         <= free_d;
      ready_q        <= ready_d;
      r_busy_q       <= r_busy_d;
      s_busy_q       <= s_busy_d;
      vblank_q       <= vblank;
      start_bin_q    <= start_bin_d;
      raster_start_q <= raster_start_d;
      stream_start_q <= stream_start_d;
      raster_id_q    <= raster_id_d;
      raster_x_q     <= raster_x_d;
      raster_y_q     <= raster_y_d;
      stream_id_q    <= stream_id_d;
      stream_x_q     <= stream_x_d;
      stream_y_q     <= stream_y_d;
      dbuf_q         <= dbuf_d;
      frame_cnt_q    <= frame_cnt_d;
      busy_q         <= busy_d;
      perr_q         <= perr_d;
    end
  end

  assign startBinning  = start_bin_q;
  assign rasterStart   = raster_start_q;
  assign rasterTileID  = raster_id_q;
  assign rasterxOffset = raster_x_q;
  assign rasteryOffset = raster_y_q;
  assign streamStart   = stream_start_q;
  assign streamTileID  = stream_id_q;
  assign streamxOffset = stream_x_q;
  assign streamyOffset = stream_y_q;
  assign doubleBuffer  = dbuf_q;
  assign frameCount    = frame_cnt_q;
  assign busy          = busy_q;
  assign protocolError = perr_q;
endmodule

// File: tb/tb_tile_frame_sequencer.sv
// Bench for tile_frame_sequencer: a 64x32 / 2-buffer and a 40x32 / 4-buffer instance
// with scripted responders; a scoreboard checks raster and stream tile order.
`timescale 1ns/1ps
module tb_tile_frame_sequencer;
  logic clk;
  logic rst, fe, fs, vb;

  logic       sb_a, db_a, rs_a, dr_a, ss_a, ds_a, dbuf_a, busy_a, perr_a, spur_ds_a, ds_in_a;
  logic [0:0] rid_a, sid_a;
  logic [9:0] rx_a, ry_a, sx_a, sy_a;
  logic [15:0] fc_a;
  logic       sb_b, db_b, rs_b, dr_b, ss_b, ds_b, dbuf_b, busy_b, perr_b;
  logic [1:0] rid_b, sid_b;
  logic [9:0] rx_b, ry_b, sx_b, sy_b;
  logic [15:0] fc_b;

  assign ds_in_a = ds_a | spur_ds_a;

  tile_frame_sequencer #(.SCREEN_W(64), .SCREEN_H(32), .TILE_DIM(16), .NUM_TILE_BUFS(2)) dut_a (
    .BOARD_CLK(clk), .Reset(rst), .frameEnable(fe), .frameStep(fs), .vblank(vb),
    .startBinning(sb_a), .doneBinning(db_a),
    .rasterStart(rs_a), .rasterTileID(rid_a), .rasterxOffset(rx_a), .rasteryOffset(ry_a),
    .doneRasterizing(dr_a),
    .streamStart(ss_a), .streamTileID(sid_a), .streamxOffset(sx_a), .streamyOffset(sy_a),
    .doneStreaming(ds_in_a),
    .doubleBuffer(dbuf_a), .frameCount(fc_a), .busy(busy_a), .protocolError(perr_a));

  tile_frame_sequencer #(.SCREEN_W(40), .SCREEN_H(32), .TILE_DIM(16), .NUM_TILE_BUFS(4)) dut_b (
    .BOARD_CLK(clk), .Reset(rst), .frameEnable(fe), .frameStep(fs), .vblank(vb),
    .startBinning(sb_b), .doneBinning(db_b),
    .rasterStart(rs_b), .rasterTileID(rid_b), .rasterxOffset(rx_b), .rasteryOffset(ry_b),
    .doneRasterizing(dr_b),
    .streamStart(ss_b), .streamTileID(sid_b), .streamxOffset(sx_b), .streamyOffset(sy_b),
    .doneStreaming(ds_b),
    .doubleBuffer(dbuf_b), .frameCount(fc_b), .busy(busy_b), .protocolError(perr_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ra[$], exp_sa[$], exp_rb[$], exp_sb[$];
  int rc_a = 0, sc_a = 0, rc_b = 0, sc_b = 0;
  int rp_a = 0, sp_a = 0, rp_b = 0, sp_b = 0;
  int rel_b = 0;
  int dbc_a = 0;
  bit first_a = 1'b0;
  bit sbp_a = 1'b0, sbp_b = 1'b0;
  bit stall_b = 1'b1;
  int e;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Tile descriptor as one integer: id<<20 | y<<10 | x.
  function automatic int tile(input int id, input int x, input int y);
    return id * 1048576 + y * 1024 + x;
  endfunction

  task automatic push_frames();
    for (int i = 0; i < 8; i++) begin
      e = tile(i % 2, (i % 4) * 16, (i / 4) * 16);
      exp_ra.push_back(e);
      exp_sa.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      e = tile(i % 4, (i % 3) * 16, (i / 3) * 16);
      exp_rb.push_back(e);
      exp_sb.push_back(e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " A pulses/ids/offsets"}, int'(|{sb_a, rs_a, ss_a, rid_a, sid_a, rx_a, ry_a, sx_a, sy_a}), 0);
    chk({tag, " A doubleBuffer"}, int'(dbuf_a), 0);
    chk({tag, " A frameCount"}, int'(fc_a), 0);
    chk({tag, " A busy"}, int'(busy_a), 0);
    chk({tag, " A protocolError"}, int'(perr_a), 0);
    chk({tag, " B pulses/ids/offsets"}, int'(|{sb_b, rs_b, ss_b, rid_b, sid_b, rx_b, ry_b, sx_b, sy_b}), 0);
    chk({tag, " B doubleBuffer"}, int'(dbuf_b), 0);
    chk({tag, " B frameCount"}, int'(fc_b), 0);
    chk({tag, " B busy"}, int'(busy_b), 0);
    chk({tag, " B protocolError"}, int'(perr_b), 0);
  endtask

  initial begin
    rst = 1'b1; fe = 1'b0; fs = 1'b0; vb = 1'b0; spur_ds_a = 1'b0;
    db_a = 1'b0; dr_a = 1'b0; ds_a = 1'b0; db_b = 1'b0; dr_b = 1'b0; ds_b = 1'b0;
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Responders: binning answers one cycle after startBinning, raster/stream at once.
      forever begin
        @(negedge clk);
        db_a = sbp_a;
        if (sbp_a) begin
          dbc_a   = cyc;
          first_a = 1'b1;
        end
        sbp_a = sb_a;
        if (rs_a) rp_a++;
        dr_a = (rp_a > 0);
        if (rp_a > 0) rp_a--;
        if (ss_a) sp_a++;
        ds_a = (sp_a > 0);
        if (sp_a > 0) sp_a--;
        db_b  = sbp_b;
        sbp_b = sb_b;
        if (rs_b) rp_b++;
        dr_b = (rp_b > 0);
        if (rp_b > 0) rp_b--;
        if (ss_b) sp_b++;
        ds_b = 1'b0;
        if (sp_b > 0 && (!stall_b || rel_b > 0)) begin
          ds_b = 1'b1;
          sp_b--;
          if (stall_b) rel_b--;
        end
      end
      // Monitor: pops the scoreboard whenever a tile is issued.
      forever begin
        @(negedge clk);
        if (rs_a) begin
          rc_a++;
          if (first_a) begin
            chk("A doneBinning->rasterStart latency", cyc, dbc_a + 2);
            first_a = 1'b0;
          end
          if (exp_ra.size() == 0) chk("A unexpected rasterStart", 1, 0);
          else chk("A raster tile", tile(int'(rid_a), int'(rx_a), int'(ry_a)), exp_ra.pop_front());
        end
        if (ss_a) begin
          sc_a++;
          if (exp_sa.size() == 0) chk("A unexpected streamStart", 1, 0);
          else chk("A stream tile", tile(int'(sid_a), int'(sx_a), int'(sy_a)), exp_sa.pop_front());
        end
        if (rs_b) begin
          rc_b++;
          if (exp_rb.size() == 0) chk("B unexpected rasterStart", 1, 0);
          else chk("B raster tile", tile(int'(rid_b), int'(rx_b), int'(ry_b)), exp_rb.pop_front());
        end
        if (ss_b) begin
          sc_b++;
          if (exp_sb.size() == 0) chk("B unexpected streamStart", 1, 0);
          else chk("B stream tile", tile(int'(sid_b), int'(sx_b), int'(sy_b)), exp_sb.pop_front());
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Spurious doneStreaming while idle.
    spur_ds_a = 1'b1;
    @(negedge clk);
    spur_ds_a = 1'b0;
    chk("A protocolError after spurious done", int'(perr_a), 1);
    chk("B protocolError untouched", int'(perr_b), 0);
    @(negedge clk);
    chk("A stays idle after spurious done", int'(busy_a), 0);
    chk("A protocolError sticky", int'(perr_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("A protocolError cleared by reset", int'(perr_a), 0);

    // Single stepped frame, vblank already high, B streamer stalled.
    push_frames();
    vb = 1'b1;
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    for (int i = 0; i < 40 && rc_b < 4; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("B rasterStarts with streamer stalled", rc_b, 4);
    chk("B streamStarts with streamer stalled", sc_b, 1);
    rel_b = 1;
    repeat (10) @(negedge clk);
    chk("B rasterStarts after one doneStreaming", rc_b, 5);
    chk("B streamStarts after one doneStreaming", sc_b, 2);
    stall_b = 1'b0;
    for (int i = 0; i < 300 && (sc_a < 8 || sc_b < 6); i++) @(negedge clk);
    chk("A rasterStarts per frame", rc_a, 8);
    chk("A streamStarts per frame", sc_a, 8);
    chk("B rasterStarts per frame", rc_b, 6);
    chk("B streamStarts per frame", sc_b, 6);
    repeat (5) @(negedge clk);
    chk("A no swap while vblank held high", int'(dbuf_a), 0);
    chk("B no swap while vblank held high", int'(dbuf_b), 0);
    chk("A busy in swap wait", int'(busy_a), 1);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    chk("A no swap on vblank fall", int'(dbuf_a), 0);
    vb = 1'b1;
    chk("A doubleBuffer before edge", int'(dbuf_a), 0);
    @(negedge clk);
    chk("A doubleBuffer toggles after edge", int'(dbuf_a), 1);
    chk("A frameCount after frame 1", int'(fc_a), 1);
    chk("B doubleBuffer toggles after edge", int'(dbuf_b), 1);
    chk("B frameCount after frame 1", int'(fc_b), 1);
    repeat (3) @(negedge clk);
    chk("A idle after stepped frame", int'(busy_a), 0);
    chk("B idle after stepped frame", int'(busy_b), 0);
    repeat (5) @(negedge clk);
    chk("A no extra tiles when idle", rc_a, 8);
    chk("scoreboard drained", exp_ra.size() + exp_sa.size() + exp_rb.size() + exp_sb.size(), 0);
    chk("A protocolError clean frame", int'(perr_a), 0);
    chk("B protocolError clean frame", int'(perr_b), 0);

    // Back-to-back frames, then reset in the middle of frame 3.
    vb = 1'b0;
    push_frames();
    fe = 1'b1;
    for (int i = 0; i < 300 && (sc_a < 16 || sc_b < 12); i++) @(negedge clk);
    chk("A streamStarts after frame 2", sc_a, 16);
    chk("B streamStarts after frame 2", sc_b, 12);
    repeat (3) @(negedge clk);
    chk("A no swap without vblank edge", int'(dbuf_a), 1);
    push_frames();
    vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    chk("A doubleBuffer frame 2", int'(dbuf_a), 0);
    chk("A frameCount after frame 2", int'(fc_a), 2);
    chk("B frameCount after frame 2", int'(fc_b), 2);
    for (int i = 0; i < 100 && rc_a < 18; i++) @(negedge clk);
    chk("A frame 3 under way", rc_a, 18);
    chk("A busy mid-frame", int'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid-frame reset");
    rst = 1'b0;
    fe = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
